// File: rtl/aes_seq_pkg.sv
// aes_seq_pkg: shared constants and types for the iterative AES-128 sequencer.
//   SBOX       - forward AES S-box, 256 entries
//   RCON       - key-schedule round constants for the ten key steps
//   ROUND_LAST - index of the final round
//   state_e    - sequencer FSM states
//   SEL_*      - core_sel encodings understood by the round datapath
package aes_seq_pkg;

  localparam logic [3:0] ROUND_LAST = 4'd10;

  localparam logic [1:0] SEL_FIRST = 2'b00;  // AddRoundKey only
  localparam logic [1:0] SEL_MID   = 2'b01;  // full round
  localparam logic [1:0] SEL_LAST  = 2'b10;  // no MixColumns

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [7:0] RCON [10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
    8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
    8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
    8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
    8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
    8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
    8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
    8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
    8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
    8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
    8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
    8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
    8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
    8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
    8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
    8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
    8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

endpackage

// File: rtl/aes_key_step.sv
// aes_key_step: one combinational AES-128 key-schedule step.
//   rk_in  [127:0] - current round key, word w0 in bits [127:96]
//   rcon   [7:0]   - round constant for this step
//   rk_out [127:0] - next round key
module aes_key_step (
  input  logic [127:0] rk_in,
  input  logic [7:0]   rcon,
  output logic [127:0] rk_out
);
  import aes_seq_pkg::*;

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] rot, sub;
  logic [31:0] n0, n1, n2, n3;

  always_comb begin
    w0  = rk_in[127:96];
    w1  = rk_in[95:64];
    w2  = rk_in[63:32];
    w3  = rk_in[31:0];
    rot = {w3[23:0], w3[31:24]};
    sub = {SBOX[rot[31:24]], SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]};
    n0  = w0 ^ sub ^ {rcon, 24'h000000};
    n1  = n0 ^ w1;
    n2  = n1 ^ w2;
    n3  = n2 ^ w3;
    rk_out = {n0, n1, n2, n3};
  end

endmodule

// File: rtl/aes_round_sequencer.sv
// aes_round_sequencer: iterative AES-128 encryption controller. Drives an external
// combinational single-round datapath for 11 cycles per block and expands the key
// on the fly.
//   CLK, RSTn         - clock, asynchronous active-low reset
//   Kin, Krdy, Kvld   - key load strobe; Kvld pulses the cycle after acceptance
//   Din, Drdy         - plaintext and encrypt strobe (accepted in IDLE with a key)
//   Dout, Dvld, BSY   - registered ciphertext, one-cycle valid pulse, busy flag
//   core_din/kin/sel  - round datapath inputs (zero outside RUN)
//   core_dout         - round datapath result, only ever registered here
// Build option: define AES_SEQ_ZEROIZE_EN to clear the state and round-key
// registers in the DONE cycle.
module aes_round_sequencer (
  input  logic         CLK,
  input  logic         RSTn,
  input  logic [127:0] Kin,
  input  logic         Krdy,
  input  logic [127:0] Din,
  input  logic         Drdy,
  output logic [127:0] Dout,
  output logic         Kvld,
  output logic         Dvld,
  output logic         BSY,
  output logic [127:0] core_din,
  output logic [127:0] core_kin,
  output logic [1:0]   core_sel,
  input  logic [127:0] core_dout
);
  import aes_seq_pkg::*;

  state_e       state_q, state_d;
  logic [3:0]   rnd_q, rnd_d;
  logic [127:0] st_q, st_d;
  logic [127:0] rk_q, rk_d;
  logic [127:0] key_q, key_d;
  logic         key_ok_q, key_ok_d;
  logic [127:0] dout_q, dout_d;
  logic         kvld_q, kvld_d;

  logic [7:0]   rcon;
  logic [127:0] rk_next;

  // RCON[rnd] derives the key for round rnd+1; the last round needs no successor.
  always_comb rcon = (rnd_q < ROUND_LAST) ? RCON[rnd_q] : 8'h00;

  aes_key_step u_key_step (
    .rk_in  (rk_q),
    .rcon   (rcon),
    .rk_out (rk_next)
  );

  always_comb begin
    state_d  = state_q;
    rnd_d    = rnd_q;
    st_d     = st_q;
    rk_d     = rk_q;
    key_d    = key_q;
    key_ok_d = key_ok_q;
    dout_d   = dout_q;
    kvld_d   = 1'b0;
    core_din = '0;
    core_kin = '0;
    core_sel = SEL_FIRST;

    unique case (state_q)
      IDLE: begin
        // Key load takes priority over a simultaneous encrypt request.
        if (Krdy) begin
          key_d    = Kin;
          key_ok_d = 1'b1;
          kvld_d   = 1'b1;
        end else if (Drdy && key_ok_q) begin
          st_d    = Din;
          rk_d    = key_q;
          rnd_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        core_din = st_q;
        core_kin = rk_q;
        if (rnd_q == '0) begin
          core_sel = SEL_FIRST;
        end else if (rnd_q == ROUND_LAST) begin
          core_sel = SEL_LAST;
        end else begin
          core_sel = SEL_MID;
        end
        st_d  = core_dout;
        rnd_d = rnd_q + 4'd1;
        if (rnd_q == ROUND_LAST) begin
          dout_d  = core_dout;
          rnd_d   = '0;
          state_d = DONE;
        end else begin
          rk_d = rk_next;
        end
      end
      DONE: begin
        state_d = IDLE;
`ifdef AES_SEQ_ZEROIZE_EN
        st_d = '0;
        rk_d = '0;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q  <= IDLE;
      rnd_q    <= '0;
      st_q     <= '0;
      rk_q     <= '0;
      key_q    <= '0;
      key_ok_q <= 1'b0;
      dout_q   <= '0;
      kvld_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rnd_q    <= rnd_d;
      st_q     <= st_d;
      rk_q     <= rk_d;
      key_q    <= key_d;
      key_ok_q <= key_ok_d;
      dout_q   <= dout_d;
      kvld_q   <= kvld_d;
    end
  end

  assign Dout = dout_q;
  assign Kvld = kvld_q;
  assign Dvld = (state_q == DONE);
  assign BSY  = (state_q != IDLE);

endmodule

// File: tb/tb_aes_round_sequencer.sv
// tb_aes_round_sequencer: bench for aes_round_sequencer with a behavioural AES
// round datapath on core_dout and a cycle-level model of the host handshake.
module tb_aes_round_sequencer;

  logic         CLK, RSTn;
  logic [127:0] Kin, Din, Dout, core_din, core_kin, core_dout;
  logic         Krdy, Drdy, Kvld, Dvld, BSY;
  logic [1:0]   core_sel;

  localparam logic [127:0] K_B    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P_B    = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] RK1_B  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] RK10_B = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] K_C    = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P_C    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_C   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  int checks = 0;
  int failures = 0;
  int dvld_count = 0;

  logic [7:0]   sbox [256];
  logic [127:0] m_rk [11];
  logic [127:0] m_st [12];

  aes_round_sequencer dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .Kin       (Kin),
    .Krdy      (Krdy),
    .Din       (Din),
    .Drdy      (Drdy),
    .Dout      (Dout),
    .Kvld      (Kvld),
    .Dvld      (Dvld),
    .BSY       (BSY),
    .core_din  (core_din),
    .core_kin  (core_kin),
    .core_sel  (core_sel),
    .core_dout (core_dout)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- AES arithmetic ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box from the GF(2^8) inverse and affine map, independent of any table.
  task automatic build_sbox();
    logic [7:0] inv, v, s;
    for (int b = 0; b < 256; b++) begin
      inv = 8'h00;
      for (int x = 1; x < 256; x++) begin
        if (gmul(8'(b), 8'(x)) == 8'h01) inv = 8'(x);
      end
      s = inv;
      v = inv;
      for (int r = 0; r < 4; r++) begin
        v = {v[6:0], v[7]};
        s = s ^ v;
      end
      sbox[b] = s ^ 8'h63;
    end
  endtask

  function automatic logic [7:0] gb(input logic [127:0] s, input int i);
    return s[127-8*i -: 8];
  endfunction

  function automatic logic [127:0] round_fn(input logic [127:0] s, input logic [127:0] k,
                                            input logic [1:0] sel);
    logic [127:0] sb, sr, mc;
    logic [7:0] a0, a1, a2, a3;
    sb = '0;
    sr = '0;
    mc = '0;
    if (sel == 2'b00) return s ^ k;
    if (sel == 2'b11) return '0;
    for (int i = 0; i < 16; i++) sb[127-8*i -: 8] = sbox[gb(s, i)];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) sr[127-8*(4*c+r) -: 8] = gb(sb, 4*((c+r)%4) + r);
    if (sel == 2'b10) return sr ^ k;
    for (int c = 0; c < 4; c++) begin
      a0 = gb(sr, 4*c);
      a1 = gb(sr, 4*c+1);
      a2 = gb(sr, 4*c+2);
      a3 = gb(sr, 4*c+3);
      mc[127-8*(4*c)   -: 8] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
      mc[127-8*(4*c+1) -: 8] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
      mc[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
      mc[127-8*(4*c+3) -: 8] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
    end
    return mc ^ k;
  endfunction

  function automatic logic [1:0] sel_of(input int r);
    return (r == 0) ? 2'b00 : ((r == 10) ? 2'b10 : 2'b01);
  endfunction

  assign core_dout = round_fn(core_din, core_kin, core_sel);

  // Full key schedule plus per-round states for one block.
  task automatic model_start(input logic [127:0] k, input logic [127:0] d);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) m_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    m_st[0] = d;
    for (int r = 0; r < 11; r++) m_st[r+1] = round_fn(m_st[r], m_rk[r], sel_of(r));
  endtask

  // ---------------- handshake model and per-cycle compare ----------------
  // age counts cycles since Drdy acceptance: 1..11 rounds, 12 completion, 0 none.
  initial begin
    int           age;
    logic         m_key_ok, m_kvld;
    logic [127:0] m_key, m_dout, e_din, e_kin;
    logic [1:0]   e_sel;
    age = 0;
    m_key_ok = 1'b0;
    m_kvld = 1'b0;
    m_key = '0;
    m_dout = '0;
    forever begin
      @(posedge CLK);
      if (!RSTn) begin
        age = 0;
        m_key_ok = 1'b0;
        m_kvld = 1'b0;
        m_key = '0;
        m_dout = '0;
      end else begin
        m_kvld = 1'b0;
        if (age == 0) begin
          if (Krdy) begin
            m_key = Kin;
            m_key_ok = 1'b1;
            m_kvld = 1'b1;
          end else if (Drdy && m_key_ok) begin
            model_start(m_key, Din);
            age = 1;
          end
        end else if (age == 12) begin
          age = 0;
        end else begin
          age++;
          if (age == 12) m_dout = m_st[11];
        end
      end
      #1;
      e_din = '0;
      e_kin = '0;
      e_sel = 2'b00;
      if (age >= 1 && age <= 11) begin
        e_din = m_st[age-1];
        e_kin = m_rk[age-1];
        e_sel = sel_of(age - 1);
      end
      if (Dvld) dvld_count++;
      check("cyc_bsy", 128'(BSY), 128'(age >= 1 && age <= 12));
      check("cyc_dvld", 128'(Dvld), 128'(age == 12));
      check("cyc_kvld", 128'(Kvld), 128'(m_kvld));
      check("cyc_dout", Dout, m_dout);
      check("cyc_core_din", core_din, e_din);
      check("cyc_core_kin", core_kin, e_kin);
      check("cyc_core_sel", 128'(core_sel), 128'(e_sel));
    end
  end

  // ---------------- directed stimulus ----------------
  int           lat;
  logic [127:0] dout_at;
  logic [1:0]   sel_log [11];
  logic [127:0] kin_log [11];

  task automatic load_key(input logic [127:0] k);
    Kin = k;
    Krdy = 1'b1;
    @(negedge CLK);
    Krdy = 1'b0;
    check("kvld_pulse", 128'(Kvld), 128'd1);
  endtask

  // Returns at the negedge where Dvld is seen (or after a bounded wait).
  task automatic run_block(input logic [127:0] d);
    Din = d;
    Drdy = 1'b1;
    @(negedge CLK);
    Drdy = 1'b0;
    lat = 0;
    dout_at = '0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      if (k <= 11) begin
        sel_log[k-1] = core_sel;
        kin_log[k-1] = core_kin;
      end
      if (Dvld) begin
        lat = k;
        dout_at = Dout;
      end else begin
        @(negedge CLK);
      end
    end
    check("dvld_latency", 128'(lat), 128'd12);
  endtask

  task automatic idle_watch(input string name, input int n);
    int hits;
    int d0;
    hits = 0;
    d0 = dvld_count;
    repeat (n) begin
      if (BSY) hits++;
      @(negedge CLK);
    end
    check({name, "_bsy"}, 128'(hits), 128'd0);
    check({name, "_dvld"}, 128'(dvld_count - d0), 128'd0);
  endtask

  initial begin
    logic [21:0] sp;
    int d0;
    build_sbox();
    RSTn = 1'b0;
    Krdy = 1'b0;
    Drdy = 1'b0;
    Kin = '0;
    Din = '0;
    repeat (3) @(negedge CLK);
    check("rst_dout", Dout, '0);
    check("rst_bsy", 128'(BSY), '0);
    check("rst_dvld", 128'(Dvld), '0);
    check("rst_kvld", 128'(Kvld), '0);
    RSTn = 1'b1;
    @(negedge CLK);

    // Encrypt request with no key loaded.
    Din = P_B;
    Drdy = 1'b1;
    @(negedge CLK);
    Drdy = 1'b0;
    idle_watch("nokey", 14);

    // Appendix-A key schedule and Appendix-B block.
    load_key(K_B);
    run_block(P_B);
    check("rk_round1", kin_log[1], RK1_B);
    check("rk_round10", kin_log[10], RK10_B);
    check("ct_fips_b", dout_at, CT_B);
    @(negedge CLK);

    // FIPS-197 C.1 then a back-to-back second block at T+13.
    load_key(K_C);
    run_block(P_C);
    check("ct_fips_c1", dout_at, CT_C);
    sp = '0;
    for (int i = 0; i < 11; i++) sp = {sp[19:0], sel_log[i]};
    check("core_sel_seq", 128'(sp), 128'(22'b00_010101010101010101_10));
    @(negedge CLK);
`ifdef AES_SEQ_ZEROIZE_EN
    check("zeroize_st_1", dut.st_q, '0);
`endif
    run_block(P_B);
    check("b2b_ct2", dout_at, m_st[11]);
    check("b2b_kin0", kin_log[0], K_C);
    @(negedge CLK);
`ifdef AES_SEQ_ZEROIZE_EN
    check("zeroize_st_2", dut.st_q, '0);
`endif

    // Krdy and Drdy together: key load wins.
    Kin = K_B;
    Krdy = 1'b1;
    Din = P_C;
    Drdy = 1'b1;
    @(negedge CLK);
    Krdy = 1'b0;
    Drdy = 1'b0;
    check("both_kvld", 128'(Kvld), 128'd1);
    idle_watch("both", 14);

    // Requests while busy are ignored.
    d0 = dvld_count;
    Din = P_C;
    Drdy = 1'b1;
    @(negedge CLK);
    Drdy = 1'b0;
    repeat (4) @(negedge CLK);
    Din = P_B;
    Drdy = 1'b1;
    Kin = K_C;
    Krdy = 1'b1;
    @(negedge CLK);
    Drdy = 1'b0;
    Krdy = 1'b0;
    repeat (20) @(negedge CLK);
    check("busy_one_dvld", 128'(dvld_count - d0), 128'd1);

    // Reset in round 5 aborts the block and forgets the key.
    Din = P_B;
    Drdy = 1'b1;
    @(negedge CLK);
    Drdy = 1'b0;
    repeat (5) @(negedge CLK);
    check("abort_pre_sel", 128'(core_sel), 128'd1);
    RSTn = 1'b0;
    #1;
    check("abort_dout", Dout, '0);
    check("abort_bsy", 128'(BSY), '0);
    check("abort_dvld", 128'(Dvld), '0);
    check("abort_kvld", 128'(Kvld), '0);
    check("abort_core", core_din | core_kin | 128'(core_sel), '0);
    @(negedge CLK);
    RSTn = 1'b1;
    @(negedge CLK);
    Din = P_B;
    Drdy = 1'b1;
    @(negedge CLK);
    Drdy = 1'b0;
    idle_watch("after_abort", 14);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
